w5300_bus_arbiter: RTL
======================

Name: w5300_bus_arbiter

Overview:
- Shares the single W5300 host-bus operation engine between N_REQ requesters: IRQ handler, socket TX, socket RX and config.
- Arbitrates by round-robin, with an optional fixed priority for requester 0 (the IRQ handler).
- Issues one 11-bit command (bit 10 = RD/WR flag, bits 9:0 = register address) plus write data to the engine per grant.
- Returns read data and a completion or timeout pulse to the granted requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PRIO0, 1, 1 = requester 0 beats round-robin whenever it requests; 0 = pure round-robin.
- TIMEOUT, 1024, maximum WAIT cycles before abort (≥2).
- TO_W, 11, timeout counter width, ≥ clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level.
- req_addr  in  N_REQ*11  packed commands; slice i = [11*i+10 : 11*i].
- req_wdata  in  N_REQ*16  packed write data; slice i = [16*i+15 : 16*i].
- gnt  out  N_REQ  one-hot grant, high ISSUE through WAIT.
- done  out  N_REQ  one-cycle completion pulse to the granted requester.
- err  out  N_REQ  one-cycle timeout pulse to the granted requester.
- rd_data  out  16  read data captured at completion; held until the next completion.
- busy  out  1  high in any state except IDLE.
- bus_start  out  1  one-cycle start strobe to the engine.
- bus_addr  out  11  registered command of the granted requester.
- bus_wdata  out  16  registered write data of the granted requester.
- bus_rdata  in  16  engine read data, valid with bus_done.
- bus_done  in  1  engine completion pulse (op_state).
- bus_abort  out  1  one-cycle abort strobe to the engine on timeout.

Behaviour:
- Synchronous reset, active-high. On reset:
  - state = IDLE, rr_ptr = 0, counter = 0.
  - All outputs 0: gnt, done, err, rd_data, busy, bus_start, bus_addr, bus_wdata, bus_abort.
- Reset mid-operation: same reset values on the next edge; no done/err pulse is generated for the dropped transfer.
- FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - If req != 0, pick the winner and go to ISSUE.
  - Register gnt[w]=1 and latch slice w of req_addr and req_wdata into bus_addr and bus_wdata.
- Winner selection:
  - If PRIO0 and req[0], the winner is 0.
  - Otherwise the winner is the first set bit of req searching upward from rr_ptr, wrapping from N_REQ-1 to 0.
- ISSUE: bus_start=1 for exactly one cycle; clear the counter; go to WAIT.
- WAIT:
  - bus_done=1 → latch bus_rdata into rd_data and go to DONE.
  - Otherwise, when counter == TIMEOUT-1 → go to ERR. Otherwise counter+1.
  - bus_done takes precedence over timeout in the same cycle.
- DONE: done[w]=1 for one cycle; gnt drops; rr_ptr = (w+1) mod N_REQ; go to IDLE.
- ERR: err[w]=1 and bus_abort=1 for one cycle; gnt drops; rd_data unchanged; rr_ptr = (w+1) mod N_REQ; go to IDLE.
- bus_done is ignored outside WAIT (late completions after an abort are discarded).
- Latency:
  - req seen in IDLE at edge k → bus_start during cycle k+1.
  - bus_done in WAIT cycle m → done pulse in cycle m+1.
  - Minimum request-to-done latency is 4 cycles.
- Requester rules:
  - Hold req, addr and data stable until done or err.
  - Deassert req in the done/err cycle, or it is treated as a new request in the next IDLE.
  - Dropping req while granted has no effect; the transfer completes.
- Simultaneous requests: exactly one gnt bit set at a time. Non-winners wait without any loss.
- Starvation: with PRIO0=0, every requester is served within N_REQ grants. With PRIO0=1, only requesters 1..N_REQ-1 can starve, and only under continuous requester-0 traffic.

Optional Feature:
- Macro: W5300_ARB_LOCK_EN.
- With it, an extra input port lock [N_REQ] is present.
- If lock[w] is high in the DONE cycle:
  - The FSM goes directly to ISSUE for the same requester, re-latching its current addr/data.
  - gnt stays high; rr_ptr does not advance.
  - The engine sees back-to-back register sequences, e.g. IR read then clear, with no interleaving.
- ERR always releases the lock.
- Without the macro the port is absent, and every DONE returns to IDLE.

Test Plan:
- Single op: req[1]=1, req_addr slice1=11'h402, bus_done after 3 WAIT cycles, bus_rdata=16'hA5C3 → bus_start at cycle+1, bus_addr=11'h402, done[1] pulse, rd_data=16'hA5C3, busy low afterwards.
- Round-robin: PRIO0=0, req=4'b1110 held, each op done in 1 cycle → grant order 1,2,3,1; never two gnt bits set.
- Priority: PRIO0=1, req=4'b1111 held → requester 0 granted each arbitration; drop req[0] → order continues 1,2,3 from rr_ptr.
- Timeout: TIMEOUT=8, bus_done never asserted → err[w] and bus_abort pulse exactly 8 WAIT cycles after ISSUE, rd_data unchanged; late bus_done in IDLE ignored.
- Reset in WAIT: assert rst during WAIT → next cycle all outputs 0, state IDLE, no done/err; pending req re-granted after rst deasserts.
- Lock (W5300_ARB_LOCK_EN): lock[0]=1 over two ops (addr 11'h402 then 11'h002, wdata 16'hFFFF) with req[2]=1 pending → both ops for requester 0 consecutively, gnt[0] continuous, then requester 2.

Source files
------------

// File: rtl/w5300_bus_arbiter.sv
// w5300_bus_arbiter: round-robin arbiter sharing the W5300 host-bus engine between requesters.
// Optional macro W5300_ARB_LOCK_EN adds a lock input for back-to-back ops by one requester.
module w5300_bus_arbiter #(
   parameter int N_REQ   = 4,
   parameter int PRIO0   = 1,
   parameter int TIMEOUT = 1024,
   parameter int TO_W    = 11
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef W5300_ARB_LOCK_EN
   input  logic [N_REQ-1:0]      lock,
`endif
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ*11-1:0]   req_addr,
   input  logic [N_REQ*16-1:0]   req_wdata,
   output logic [N_REQ-1:0]      gnt,
   output logic [N_REQ-1:0]      done,
   output logic [N_REQ-1:0]      err,
   output logic [15:0]           rd_data,
   output logic                  busy,
   output logic                  bus_start,
   output logic [10:0]           bus_addr,
   output logic [15:0]           bus_wdata,
   input  logic [15:0]           bus_rdata,
   input  logic                  bus_done,
   output logic                  bus_abort
);
   localparam int IW = $clog2(N_REQ);
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;
   state_t            state_q;
   logic [IW-1:0]     w_q, rr_q, win_d, sel_d;
   logic [TO_W-1:0]   cnt_q;
   logic [N_REQ-1:0]  gnt_q, done_q, err_q;
   logic [15:0]       rd_data_q, bus_wdata_q;
   logic [10:0]       bus_addr_q;
   logic              busy_q, bus_start_q, bus_abort_q, lock_w;
   // Lowest offset from the round-robin pointer wins; requester 0 may pre-empt it.
   function automatic logic [IW-1:0] pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] p);
      pick = p;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (r[(int'(p) + i) % N_REQ]) pick = IW'((int'(p) + i) % N_REQ);
      if (PRIO0 != 0 && r[0]) pick = '0;
   endfunction
`ifdef W5300_ARB_LOCK_EN
   assign lock_w = lock[w_q];
`else
   assign lock_w = 1'b0;
`endif
   assign win_d = pick(req, rr_q);
   assign sel_d = (state_q == S_IDLE) ? win_d : w_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         w_q         <= '0;
         rr_q        <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         err_q       <= '0;
         rd_data_q   <= '0;
         busy_q      <= 1'b0;
         bus_start_q <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_abort_q <= 1'b0;
      end else begin
         bus_start_q <= 1'b0;
         done_q      <= '0;
         err_q       <= '0;
         bus_abort_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if ((state_q == S_IDLE && |req) || (state_q == S_DONE && lock_w)) begin
                  state_q     <= S_ISSUE;
                  w_q         <= sel_d;
                  gnt_q       <= N_REQ'(1) << sel_d;
                  bus_addr_q  <= req_addr[11*sel_d +: 11];
                  bus_wdata_q <= req_wdata[16*sel_d +: 16];
                  bus_start_q <= 1'b1;
                  busy_q      <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  if (state_q == S_DONE) rr_q <= (w_q == IW'(N_REQ - 1)) ? '0 : w_q + 1'b1;
               end
            end
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (bus_done) begin
                  state_q      <= S_DONE;
                  rd_data_q    <= bus_rdata;
                  done_q[w_q]  <= 1'b1;
                  gnt_q        <= lock_w ? gnt_q : '0;
               end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                  state_q     <= S_ERR;
                  err_q[w_q]  <= 1'b1;
                  bus_abort_q <= 1'b1;
                  gnt_q       <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               rr_q    <= (w_q == IW'(N_REQ - 1)) ? '0 : w_q + 1'b1;
            end
         endcase
      end
   end
   assign gnt       = gnt_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rd_data   = rd_data_q;
   assign busy      = busy_q;
   assign bus_start = bus_start_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_abort = bus_abort_q;
endmodule
